sram_dp_param: RTL and testbench

Parametrised single-clock true-dual-port RAM: the next generation of the fixed 2048×8 dual-port SRAM in the virtual prototype.

- Adds configurable width and depth, per-byte write enables, and selectable read latency.
- Resolves same-address collisions deterministically.
- Runs a hardware clear sweep after reset or on request.
- Serves as backing store for caches, frame buffers and scratchpads that need a known-zero initial state.

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_dp_param_if.sv | 35 +++
 rtl/sram_read_pipe.sv | 42 ++++
 rtl/sram_dp_param.sv | 140 ++++++++++++++
 tb/tb_sram_dp_param.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the parametrised dual-port RAM: collision modes and
// the clear/ready state encoding.
package sram_pkg;

  localparam int COLLIDE_WRITE_FIRST = 0;
  localparam int COLLIDE_READ_FIRST  = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/sram_dp_param_if.sv
// Access bus of the dual-port RAM: clear control, ready flag and both
// read/write ports. The master drives requests, the RAM is the slave.
interface sram_dp_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  clearRequest;
  logic                  ready;
  logic                  readEnableA;
  logic                  readEnableB;
  logic [NB-1:0]         writeEnableA;
  logic [NB-1:0]         writeEnableB;
  logic [ADDR_WIDTH-1:0] addressA;
  logic [ADDR_WIDTH-1:0] addressB;
  logic [DATA_WIDTH-1:0] dataInA;
  logic [DATA_WIDTH-1:0] dataInB;
  logic [DATA_WIDTH-1:0] dataOutA;
  logic [DATA_WIDTH-1:0] dataOutB;
  logic                  dataValidA;
  logic                  dataValidB;

  modport master (
    output clearRequest, readEnableA, readEnableB, writeEnableA, writeEnableB,
    output addressA, addressB, dataInA, dataInB,
    input  ready, dataOutA, dataOutB, dataValidA, dataValidB
  );

  modport slave (
    input  clearRequest, readEnableA, readEnableB, writeEnableA, writeEnableB,
    input  addressA, addressB, dataInA, dataInB,
    output ready, dataOutA, dataOutB, dataValidA, dataValidB
  );
endinterface

// File: rtl/sram_read_pipe.sv
// Optional extra output register stage for one read port. Data only loads on
// valid so the output holds its last read value.
module sram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  generate
    if (READ_LATENCY == 2) begin : g_stage
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_valid;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= i_valid;
          if (i_valid) begin
            r_data <= i_data;
          end
        end
      end

      assign o_data  = r_data;
      assign o_valid = r_valid;
    end else begin : g_bypass
      logic w_unused_clk;
      assign w_unused_clk = i_clk ^ i_rst_n;
      assign o_data       = i_data;
      assign o_valid      = i_valid;
    end
  endgenerate

endmodule

// File: rtl/sram_dp_param.sv
// Parametrised single-clock true-dual-port RAM with byte-lane writes,
// deterministic collision handling and a zero-fill sweep after reset/request.
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = COLLIDE_WRITE_FIRST
) (
  input logic            clock,
  input logic            nReset,
  sram_dp_param_if.slave bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HW    = ADDR_WIDTH - 1;

  state_t                r_state;
  logic [HW-1:0]         r_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_sweep, w_accept;
  logic                  w_re_a, w_re_b;
  logic [NB-1:0]         w_we_a, w_we_b;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b;
  logic [DATA_WIDTH-1:0] w_wd_a, w_wd_b;
  logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
  logic [DATA_WIDTH-1:0] w_rword_a, w_rword_b;
  logic [DATA_WIDTH-1:0] r_rd_a, r_rd_b;
  logic                  r_rv_a, r_rv_b;
  logic [DATA_WIDTH-1:0] w_dout_a, w_dout_b;
  logic                  w_dval_a, w_dval_b;

  // The sweep splits the array in halves so both ports finish in 2^(AW-1) cycles.
  assign w_sweep  = (r_state == ST_CLEAR);
  assign w_accept = (r_state == ST_READY) && !bus.clearRequest;
  assign w_we_a   = w_sweep ? '1 : (w_accept ? bus.writeEnableA : '0);
  assign w_we_b   = w_sweep ? '1 : (w_accept ? bus.writeEnableB : '0);
  assign w_addr_a = w_sweep ? {1'b0, r_cnt} : bus.addressA;
  assign w_addr_b = w_sweep ? {1'b1, r_cnt} : bus.addressB;
  assign w_wd_a   = w_sweep ? '0 : bus.dataInA;
  assign w_wd_b   = w_sweep ? '0 : bus.dataInB;
  assign w_re_a   = w_accept && bus.readEnableA;
  assign w_re_b   = w_accept && bus.readEnableB;
  assign w_old_a  = r_mem[bus.addressA];
  assign w_old_b  = r_mem[bus.addressB];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + HW'(1);
          if (r_cnt == '1) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          if (bus.clearRequest) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Port A lanes are written last so they win a same-address collision.
  always_ff @(posedge clock) begin
    for (int l = 0; l < NB; l++) begin
      if (w_we_b[l]) r_mem[w_addr_b][l*8 +: 8] <= w_wd_b[l*8 +: 8];
      if (w_we_a[l]) r_mem[w_addr_a][l*8 +: 8] <= w_wd_a[l*8 +: 8];
    end
  end

  generate
    if (COLLISION_MODE == COLLIDE_READ_FIRST) begin : g_read_first
      assign w_rword_a = w_old_a;
      assign w_rword_b = w_old_b;
    end else begin : g_write_first
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_rword_a[gi*8 +: 8] =
          (w_we_a[gi] && (w_addr_a == bus.addressA)) ? w_wd_a[gi*8 +: 8] :
          (w_we_b[gi] && (w_addr_b == bus.addressA)) ? w_wd_b[gi*8 +: 8] :
                                                        w_old_a[gi*8 +: 8];
        assign w_rword_b[gi*8 +: 8] =
          (w_we_a[gi] && (w_addr_a == bus.addressB)) ? w_wd_a[gi*8 +: 8] :
          (w_we_b[gi] && (w_addr_b == bus.addressB)) ? w_wd_b[gi*8 +: 8] :
                                                        w_old_b[gi*8 +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_rv_a <= 1'b0;
      r_rv_b <= 1'b0;
    end else begin
      r_rv_a <= w_re_a;
      r_rv_b <= w_re_b;
      if (w_re_a) r_rd_a <= w_rword_a;
      if (w_re_b) r_rd_b <= w_rword_b;
    end
  end

  sram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
    .i_clk  (clock),
    .i_rst_n(nReset),
    .i_data (r_rd_a),
    .i_valid(r_rv_a),
    .o_data (w_dout_a),
    .o_valid(w_dval_a)
  );

  sram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
    .i_clk  (clock),
    .i_rst_n(nReset),
    .i_data (r_rd_b),
    .i_valid(r_rv_b),
    .o_data (w_dout_b),
    .o_valid(w_dval_b)
  );

  assign bus.ready      = r_ready;
  assign bus.dataOutA   = w_dout_a;
  assign bus.dataOutB   = w_dout_b;
  assign bus.dataValidA = w_dval_a;
  assign bus.dataValidB = w_dval_b;

endmodule

// File: tb/tb_sram_dp_param.sv
// Directed bench: three RAM instances (write-first, read-first, two-cycle
// latency) share one stimulus stream driven onto bus0.
module tb_sram_dp_param;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cnt;
  logic saw_valid;

  always #5 clk = ~clk;

  sram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus0 ();
  sram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus1 ();
  sram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus2 ();

  sram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(1),
                  .COLLISION_MODE(COLLIDE_WRITE_FIRST))
    u_dut0 (.clock(clk), .nReset(rst_n), .bus(bus0));
  sram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(1),
                  .COLLISION_MODE(COLLIDE_READ_FIRST))
    u_dut1 (.clock(clk), .nReset(rst_n), .bus(bus1));
  sram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(2),
                  .COLLISION_MODE(COLLIDE_WRITE_FIRST))
    u_dut2 (.clock(clk), .nReset(rst_n), .bus(bus2));

  assign bus1.clearRequest = bus0.clearRequest;
  assign bus1.readEnableA  = bus0.readEnableA;
  assign bus1.readEnableB  = bus0.readEnableB;
  assign bus1.writeEnableA = bus0.writeEnableA;
  assign bus1.writeEnableB = bus0.writeEnableB;
  assign bus1.addressA     = bus0.addressA;
  assign bus1.addressB     = bus0.addressB;
  assign bus1.dataInA      = bus0.dataInA;
  assign bus1.dataInB      = bus0.dataInB;
  assign bus2.clearRequest = bus0.clearRequest;
  assign bus2.readEnableA  = bus0.readEnableA;
  assign bus2.readEnableB  = bus0.readEnableB;
  assign bus2.writeEnableA = bus0.writeEnableA;
  assign bus2.writeEnableB = bus0.writeEnableB;
  assign bus2.addressA     = bus0.addressA;
  assign bus2.addressB     = bus0.addressB;
  assign bus2.dataInA      = bus0.dataInA;
  assign bus2.dataInB      = bus0.dataInB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.clearRequest = 1'b0;
    bus0.readEnableA  = 1'b0;
    bus0.readEnableB  = 1'b0;
    bus0.writeEnableA = 4'h0;
    bus0.writeEnableB = 4'h0;
    bus0.addressA     = '0;
    bus0.addressB     = '0;
    bus0.dataInA      = '0;
    bus0.dataInB      = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_ready", {31'd0, bus0.ready}, 32'd0);
    chk("rst_doutA", bus0.dataOutA, 32'd0);
    chk("rst_validB", {31'd0, bus0.dataValidB}, 32'd0);
    chk("rst_lat2_doutA", bus2.dataOutA, 32'd0);

    // Power-up sweep length
    rst_n = 1'b1;
    cnt = 0;
    do begin cyc(); cnt++; end while (!bus0.ready && cnt < 1100);
    chk("init_clear_len", cnt, 32'd1024);
    chk("init_ready_lat2", {31'd0, bus2.ready}, 32'd1);

    // Swept corners read back zero
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd0;
    bus0.readEnableB = 1'b1; bus0.addressB = 11'd1023;
    cyc(); idle();
    chk("rd0_validA", {31'd0, bus0.dataValidA}, 32'd1);
    chk("rd0_doutA", bus0.dataOutA, 32'd0);
    chk("rd1023_validB", {31'd0, bus0.dataValidB}, 32'd1);
    chk("rd1023_doutB", bus0.dataOutB, 32'd0);
    cyc();
    chk("rd_pulse_validA", {31'd0, bus0.dataValidA}, 32'd0);
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd1024;
    bus0.readEnableB = 1'b1; bus0.addressB = 11'd2047;
    cyc(); idle();
    chk("rd1024_doutA", bus0.dataOutA, 32'd0);
    chk("rd2047_validB", {31'd0, bus0.dataValidB}, 32'd1);
    chk("rd2047_doutB", bus0.dataOutB, 32'd0);

    // Byte-enable write then read on the other port
    bus0.writeEnableA = 4'b1111; bus0.addressA = 11'd5; bus0.dataInA = 32'hAABBCCDD;
    cyc();
    bus0.writeEnableA = 4'b0101; bus0.dataInA = 32'h11223344;
    cyc(); idle();
    bus0.readEnableB = 1'b1; bus0.addressB = 11'd5;
    cyc(); idle();
    chk("byte_en_doutB", bus0.dataOutB, 32'hAA22CC44);
    cyc();
    chk("hold_doutB", bus0.dataOutB, 32'hAA22CC44);

    // Both ports write one address
    bus0.writeEnableA = 4'b0001; bus0.addressA = 11'd9; bus0.dataInA = 32'h000000FF;
    bus0.writeEnableB = 4'b1111; bus0.addressB = 11'd9; bus0.dataInB = 32'h12345678;
    cyc(); idle();
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd9;
    cyc(); idle();
    chk("dual_wr_doutA", bus0.dataOutA, 32'h123456FF);

    // Cross-port read/write collision
    bus0.writeEnableA = 4'b1111; bus0.addressA = 11'd3; bus0.dataInA = 32'hDEADBEEF;
    bus0.readEnableB = 1'b1; bus0.addressB = 11'd3;
    cyc(); idle();
    chk("rw_wf_doutB", bus0.dataOutB, 32'hDEADBEEF);
    chk("rw_rf_doutB", bus1.dataOutB, 32'h00000000);
    chk("rw_lat2_validB_early", {31'd0, bus2.dataValidB}, 32'd0);
    cyc();
    chk("rw_lat2_doutB", bus2.dataOutB, 32'hDEADBEEF);

    // Same-port read of its own write address
    bus0.writeEnableA = 4'b0011; bus0.addressA = 11'd4; bus0.dataInA = 32'h01020304;
    bus0.readEnableA = 1'b1;
    cyc(); idle();
    chk("self_wf_doutA", bus0.dataOutA, 32'h00000304);
    chk("self_rf_doutA", bus1.dataOutA, 32'h00000000);

    // Streaming reads: latency 1 vs latency 2
    for (int i = 0; i < 8; i++) begin
      bus0.writeEnableA = 4'hF; bus0.addressA = i[10:0]; bus0.dataInA = 32'hC0DE0000 + i;
      cyc();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      bus0.readEnableA = 1'b1; bus0.addressA = i[10:0];
      cyc();
      chk($sformatf("stream_l1_data%0d", i), bus0.dataOutA, 32'hC0DE0000 + i);
      if (i == 0) begin
        chk("stream_l2_valid0", {31'd0, bus2.dataValidA}, 32'd0);
      end else begin
        chk($sformatf("stream_l2_valid%0d", i), {31'd0, bus2.dataValidA}, 32'd1);
        chk($sformatf("stream_l2_data%0d", i - 1), bus2.dataOutA, 32'hC0DE0000 + i - 1);
      end
    end
    idle();
    cyc();
    chk("stream_l2_valid_last", {31'd0, bus2.dataValidA}, 32'd1);
    chk("stream_l2_data7", bus2.dataOutA, 32'hC0DE0007);
    cyc();
    chk("stream_l2_valid_end", {31'd0, bus2.dataValidA}, 32'd0);

    // Clear on request, with writes/reads held through the sweep
    bus0.clearRequest = 1'b1;
    bus0.writeEnableA = 4'hF; bus0.addressA = 11'd100; bus0.dataInA = 32'hFFFFFFFF;
    bus0.readEnableA  = 1'b1;
    bus0.writeEnableB = 4'hF; bus0.addressB = 11'd200; bus0.dataInB = 32'h55555555;
    cyc();
    bus0.clearRequest = 1'b0;
    chk("clr_ready_drop", {31'd0, bus0.ready}, 32'd0);
    chk("clr_no_validA", {31'd0, bus0.dataValidA}, 32'd0);
    cnt = 0;
    saw_valid = 1'b0;
    do begin
      cyc(); cnt++;
      if (bus0.dataValidA || bus0.dataValidB) saw_valid = 1'b1;
      bus0.clearRequest = (cnt == 9);
    end while (!bus0.ready && cnt < 1100);
    idle();
    chk("clr_len", cnt, 32'd1024);
    chk("clr_no_valid_window", {31'd0, saw_valid}, 32'd0);
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd5;
    bus0.readEnableB = 1'b1; bus0.addressB = 11'd200;
    cyc();
    bus0.addressA = 11'd100; bus0.addressB = 11'd9;
    chk("clr_addr5", bus0.dataOutA, 32'd0);
    chk("clr_addr200", bus0.dataOutB, 32'd0);
    cyc(); idle();
    chk("clr_addr100", bus0.dataOutA, 32'd0);
    chk("clr_addr9", bus0.dataOutB, 32'd0);

    // Refill one word, then reset with a two-cycle read in flight
    bus0.writeEnableA = 4'hF; bus0.addressA = 11'd7; bus0.dataInA = 32'hCAFEF00D;
    cyc(); idle();
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd7;
    cyc(); idle();
    rst_n = 1'b0;
    #1;
    chk("inflight_l2_valid", {31'd0, bus2.dataValidA}, 32'd0);
    chk("inflight_l2_dout", bus2.dataOutA, 32'd0);
    chk("inflight_l1_dout", bus0.dataOutA, 32'd0);
    cyc();
    chk("inflight_l2_valid_later", {31'd0, bus2.dataValidA}, 32'd0);
    rst_n = 1'b1;
    repeat (500) cyc();
    chk("mid_sweep_ready", {31'd0, bus0.ready}, 32'd0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cnt = 0;
    do begin cyc(); cnt++; end while (!bus0.ready && cnt < 1100);
    chk("restart_clear_len", cnt, 32'd1024);
    bus0.readEnableA = 1'b1; bus0.addressA = 11'd7;
    cyc(); idle();
    chk("restart_addr7", bus0.dataOutA, 32'd0);
    chk("restart_validA", {31'd0, bus0.dataValidA}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
